alarm_sequencer: RTL and testbench

Parametrised alarm tune player, the successor of the fixed 13-state alarm FSM. It plays a software-written pattern of one-hot notes plus a light flag from an internal step memory. Programmable pattern length, step period, repeat count and a snooze pause are supported. It sits between the wake-up timer (start/stop/snooze) and the buzzer/LED drivers (beat/light).

---
 rtl/alarm_pkg.sv | 19 +
 rtl/alarm_step_timer.sv | 52 +++++
 rtl/alarm_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alarm_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm tune player: state encoding,
// default geometry and the named notes used by firmware patterns.
package alarm_pkg;

    localparam int NOTE_W_DEF    = 13;
    localparam int MAX_STEPS_DEF = 16;

    localparam logic [12:0] NOTE_LOW = 13'h0001;
    localparam logic [12:0] NOTE_MID = 13'h0200;
    localparam logic [12:0] NOTE_HI2 = 13'h0400;
    localparam logic [12:0] NOTE_TOP = 13'h1000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_e;

endpackage

// File: rtl/alarm_step_timer.sv
// Step and snooze timing for the alarm player: a tick counter that paces
// pattern steps and a down-counter that times a snooze pause.
module alarm_step_timer
    import alarm_pkg::*;
#(
    parameter int PERIOD_W     = 16,
    parameter int SNOOZE_STEPS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_tick_en,
    input  logic                i_snooze_en,
    input  logic                i_snooze_load,
    input  logic [PERIOD_W-1:0] i_period,
    output logic                o_step_end,
    output logic                o_snooze_end
);

    localparam int CNT_W = PERIOD_W + $clog2(SNOOZE_STEPS + 1);

    logic [PERIOD_W-1:0] r_tick;
    logic [CNT_W-1:0]    r_snooze_cnt;
    logic [CNT_W-1:0]    w_snooze_load_val;
    logic                w_step_end;

    assign w_step_end        = i_tick_en && (r_tick == i_period - PERIOD_W'(1));
    assign w_snooze_load_val = CNT_W'(SNOOZE_STEPS) * CNT_W'(i_period) - CNT_W'(1);

    assign o_step_end   = w_step_end;
    assign o_snooze_end = i_snooze_en && (r_snooze_cnt == '0);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tick       <= '0;
            r_snooze_cnt <= '0;
        end else begin
            if (!i_tick_en || w_step_end)
                r_tick <= '0;
            else
                r_tick <= r_tick + PERIOD_W'(1);

            if (i_snooze_load)
                r_snooze_cnt <= w_snooze_load_val;
            else if (!i_snooze_en)
                r_snooze_cnt <= '0;
            else if (r_snooze_cnt != '0)
                r_snooze_cnt <= r_snooze_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm tune player: steps through a software-written pattern of one-hot
// notes plus a light flag, with repeat count, snooze pause and stop.
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int NOTE_W       = NOTE_W_DEF,
    parameter int MAX_STEPS    = MAX_STEPS_DEF,
    parameter int PERIOD_W     = 16,
    parameter int REP_W        = 4,
    parameter int SNOOZE_STEPS = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         snooze,
    input  logic [$clog2(MAX_STEPS)-1:0] cfg_len,
    input  logic [PERIOD_W-1:0]          cfg_period,
    input  logic [REP_W-1:0]             cfg_repeats,
    input  logic                         wr_en,
    input  logic [$clog2(MAX_STEPS)-1:0] wr_addr,
    input  logic [NOTE_W-1:0]            wr_beat,
    input  logic                         wr_light,
    output logic                         light,
    output logic [NOTE_W-1:0]            beat,
    output logic                         busy,
    output logic [$clog2(MAX_STEPS)-1:0] step_idx,
    output logic                         done
);

    localparam int                ADDR_W    = $clog2(MAX_STEPS);
    localparam logic [ADDR_W:0]   MEM_DEPTH = (ADDR_W + 1)'(MAX_STEPS);
    localparam logic [ADDR_W-1:0] LAST_MAX  = ADDR_W'(MAX_STEPS - 1);

    state_e              r_state;
    logic [ADDR_W-1:0]   r_step;
    logic [ADDR_W-1:0]   r_last;
    logic [REP_W-1:0]    r_pass;
    logic [REP_W-1:0]    r_repeats;
    logic [PERIOD_W-1:0] r_period;
    logic [NOTE_W-1:0]   r_beat;
    logic                r_light;
    logic                r_done;

    logic [NOTE_W-1:0]   r_mem_beat  [MAX_STEPS];
    logic                r_mem_light [MAX_STEPS];

    logic                w_wr_ok;
    logic [ADDR_W-1:0]   w_cfg_last;
    logic [ADDR_W-1:0]   w_step_next;
    logic [REP_W-1:0]    w_pass_inc;
    logic                w_step_end;
    logic                w_snooze_end;
    logic                w_snooze_load;

    assign w_wr_ok       = ({1'b0, wr_addr} < MEM_DEPTH);
    assign w_cfg_last    = (cfg_len == '0 || {1'b0, cfg_len} > MEM_DEPTH) ? LAST_MAX
                                                                           : cfg_len - ADDR_W'(1);
    assign w_step_next   = r_step + ADDR_W'(1);
    assign w_pass_inc    = (r_pass == '1) ? r_pass : r_pass + REP_W'(1);
    assign w_snooze_load = snooze && !stop && (r_state != ST_IDLE);

    alarm_step_timer #(
        .PERIOD_W     (PERIOD_W),
        .SNOOZE_STEPS (SNOOZE_STEPS)
    ) u_timer (
        .clock         (clock),
        .reset         (reset),
        .i_tick_en     (r_state == ST_PLAY),
        .i_snooze_en   (r_state == ST_SNOOZE),
        .i_snooze_load (w_snooze_load),
        .i_period      (r_period),
        .o_step_end    (w_step_end),
        .o_snooze_end  (w_snooze_end)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_step    <= '0;
            r_last    <= '0;
            r_pass    <= '0;
            r_repeats <= '0;
            r_period  <= '0;
            r_beat    <= '0;
            r_light   <= 1'b0;
            r_done    <= 1'b0;
            // NOTE: the pattern memory is cleared on reset so a stale tune never plays afterwards.
            for (int i = 0; i < MAX_STEPS; i++) begin
                r_mem_beat[i]  <= '0;
                r_mem_light[i] <= 1'b0;
            end
        end else begin
            r_done <= 1'b0;
            if (wr_en && w_wr_ok) begin
                r_mem_beat[wr_addr]  <= wr_beat;
                r_mem_light[wr_addr] <= wr_light;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        r_state   <= ST_PLAY;
                        r_last    <= w_cfg_last;
                        r_period  <= (cfg_period == '0) ? PERIOD_W'(1) : cfg_period;
                        r_repeats <= cfg_repeats;
                        r_step    <= '0;
                        r_pass    <= '0;
                        r_beat    <= r_mem_beat[0];
                        r_light   <= r_mem_light[0];
                    end
                end
                ST_PLAY: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_step  <= '0;
                        r_beat  <= '0;
                        r_light <= 1'b0;
                    end else if (snooze) begin
                        r_state <= ST_SNOOZE;
                        r_beat  <= '0;
                        r_light <= 1'b0;
                    end else if (w_step_end) begin
                        if (r_step == r_last) begin
                            // A zero repeat count never completes; pass just saturates.
                            if (r_repeats != '0 && w_pass_inc == r_repeats) begin
                                r_state <= ST_IDLE;
                                r_step  <= '0;
                                r_beat  <= '0;
                                r_light <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_step  <= '0;
                                r_pass  <= w_pass_inc;
                                r_beat  <= r_mem_beat[0];
                                r_light <= r_mem_light[0];
                            end
                        end else begin
                            r_step  <= w_step_next;
                            r_beat  <= r_mem_beat[w_step_next];
                            r_light <= r_mem_light[w_step_next];
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (stop) begin
                        r_state <= ST_IDLE;
                        r_step  <= '0;
                    end else if (!snooze && w_snooze_end) begin
                        r_state <= ST_PLAY;
                        r_step  <= '0;
                        r_beat  <= r_mem_beat[0];
                        r_light <= r_mem_light[0];
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_step  <= '0;
                    r_beat  <= '0;
                    r_light <= 1'b0;
                end
            endcase
        end
    end

    assign light    = r_light;
    assign beat     = r_beat;
    assign busy     = (r_state != ST_IDLE);
    assign step_idx = r_step;
    assign done     = r_done;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer: a vector table for the basic tune and
// stop cases, plus hand-written sequences for wrap, snooze and corner events.
module tb_alarm_sequencer;
    import alarm_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        snooze = 1'b0;
    logic [3:0]  cfg_len = 4'd0;
    logic [15:0] cfg_period = 16'd0;
    logic [3:0]  cfg_repeats = 4'd0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = 4'd0;
    logic [12:0] wr_beat = 13'd0;
    logic        wr_light = 1'b0;
    logic        light;
    logic [12:0] beat;
    logic        busy;
    logic [3:0]  step_idx;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        start;
        logic        stop;
        logic        snooze;
        logic [12:0] beat;
        logic        light;
        logic        busy;
        logic        done;
        logic [3:0]  step;
    } vec_t;

    vec_t vecs[14];

    alarm_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .snooze      (snooze),
        .cfg_len     (cfg_len),
        .cfg_period  (cfg_period),
        .cfg_repeats (cfg_repeats),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_beat     (wr_beat),
        .wr_light    (wr_light),
        .light       (light),
        .beat        (beat),
        .busy        (busy),
        .step_idx    (step_idx),
        .done        (done)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [12:0] b, input logic l,
                              input logic bz, input logic d, input logic [3:0] s);
        check({tag, ".beat"},  32'(beat),     32'(b));
        check({tag, ".light"}, 32'(light),    32'(l));
        check({tag, ".busy"},  32'(busy),     32'(bz));
        check({tag, ".done"},  32'(done),     32'(d));
        check({tag, ".step"},  32'(step_idx), 32'(s));
    endtask

    task automatic wr(input logic [3:0] a, input logic [12:0] b, input logic l);
        wr_en    = 1'b1;
        wr_addr  = a;
        wr_beat  = b;
        wr_light = l;
        cyc();
        wr_en    = 1'b0;
    endtask

    task automatic set_cfg(input logic [3:0] len, input logic [15:0] per, input logic [3:0] rep);
        cfg_len     = len;
        cfg_period  = per;
        cfg_repeats = rep;
    endtask

    task automatic load_tune();
        wr(4'd0, NOTE_MID, 1'b1);
        wr(4'd1, NOTE_HI2, 1'b0);
        wr(4'd2, NOTE_TOP, 1'b0);
    endtask

    initial begin
        // Vector i is driven during cycle i; expectations are the outputs in cycle i+1.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, NOTE_MID, 1'b1, 1'b1, 1'b0, 4'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, NOTE_MID, 1'b1, 1'b1, 1'b0, 4'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, NOTE_HI2, 1'b0, 1'b1, 1'b0, 4'd1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, NOTE_HI2, 1'b0, 1'b1, 1'b0, 4'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, NOTE_TOP, 1'b0, 1'b1, 1'b0, 4'd2};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, NOTE_TOP, 1'b0, 1'b1, 1'b0, 4'd2};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 13'h0,    1'b0, 1'b0, 1'b1, 4'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 13'h0,    1'b0, 1'b0, 1'b0, 4'd0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, NOTE_MID, 1'b1, 1'b1, 1'b0, 4'd0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, NOTE_MID, 1'b1, 1'b1, 1'b0, 4'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, NOTE_HI2, 1'b0, 1'b1, 1'b0, 4'd1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, NOTE_HI2, 1'b0, 1'b1, 1'b0, 4'd1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 13'h0,    1'b0, 1'b0, 1'b0, 4'd0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 13'h0,    1'b0, 1'b0, 1'b0, 4'd0};

        reset = 1'b1;
        cyc();
        cyc();
        expect_out("reset", 13'h0, 1'b0, 1'b0, 1'b0, 4'd0);
        reset = 1'b0;

        // Basic three-step tune, then a run stopped mid-step.
        load_tune();
        set_cfg(4'd3, 16'd2, 4'd1);
        for (int i = 0; i < 14; i++) begin
            start  = vecs[i].start;
            stop   = vecs[i].stop;
            snooze = vecs[i].snooze;
            cyc();
            expect_out($sformatf("vec%0d", i), vecs[i].beat, vecs[i].light,
                       vecs[i].busy, vecs[i].done, vecs[i].step);
        end
        start  = 1'b0;
        stop   = 1'b0;
        snooze = 1'b0;

        // Infinite playback: alternate two steps, never complete.
        wr(4'd0, NOTE_LOW, 1'b1);
        wr(4'd1, NOTE_TOP, 1'b0);
        set_cfg(4'd2, 16'd1, 4'd0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            check($sformatf("wrap%0d.beat", k), 32'(beat), (k % 2 == 0) ? 32'(NOTE_LOW) : 32'(NOTE_TOP));
            check($sformatf("wrap%0d.done", k), 32'(done), 32'd0);
            cyc();
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        expect_out("wrap_stop", 13'h0, 1'b0, 1'b0, 1'b0, 4'd0);

        // Snooze during step 1 of pass 0 with two passes configured.
        load_tune();
        set_cfg(4'd3, 16'd2, 4'd2);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        expect_out("snz_pre", NOTE_HI2, 1'b0, 1'b1, 1'b0, 4'd1);
        snooze = 1'b1;
        cyc();
        snooze = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("snz%0d.beat", k), 32'(beat), 32'd0);
            check($sformatf("snz%0d.light", k), 32'(light), 32'd0);
            check($sformatf("snz%0d.busy", k), 32'(busy), 32'd1);
            check($sformatf("snz%0d.step", k), 32'(step_idx), 32'd1);
            cyc();
        end
        expect_out("snz_resume", NOTE_MID, 1'b1, 1'b1, 1'b0, 4'd0);
        repeat (5) cyc();
        expect_out("snz_p0_end", NOTE_TOP, 1'b0, 1'b1, 1'b0, 4'd2);
        cyc();
        expect_out("snz_p1", NOTE_MID, 1'b1, 1'b1, 1'b0, 4'd0);
        repeat (5) cyc();
        expect_out("snz_p1_end", NOTE_TOP, 1'b0, 1'b1, 1'b0, 4'd2);
        cyc();
        expect_out("snz_done", 13'h0, 1'b0, 1'b0, 1'b1, 4'd0);

        // Stop while snoozing.
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        snooze = 1'b1;
        cyc();
        snooze = 1'b0;
        repeat (4) cyc();
        expect_out("snzstop_pre", 13'h0, 1'b0, 1'b1, 1'b0, 4'd1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        expect_out("snzstop", 13'h0, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc();
        expect_out("snzstop_after", 13'h0, 1'b0, 1'b0, 1'b0, 4'd0);

        // Full-depth pattern (len 0) at one step per clock (period 0).
        for (int i = 0; i < 16; i++) wr(4'(i), 13'(i + 1), i[0]);
        set_cfg(4'd0, 16'd0, 4'd1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            expect_out($sformatf("edge%0d", k), 13'(k + 1), k[0], 1'b1, 1'b0, 4'(k));
            cyc();
        end
        expect_out("edge_done", 13'h0, 1'b0, 1'b0, 1'b1, 4'd0);

        // Live write to step 1 during step 0, start while busy, stop+snooze together.
        load_tune();
        set_cfg(4'd3, 16'd2, 4'd1);
        start = 1'b1;
        cyc();
        start    = 1'b0;
        wr_en    = 1'b1;
        wr_addr  = 4'd1;
        wr_beat  = NOTE_LOW;
        wr_light = 1'b1;
        cyc();
        wr_en = 1'b0;
        expect_out("live_s0", NOTE_MID, 1'b1, 1'b1, 1'b0, 4'd0);
        cyc();
        expect_out("live_s1", NOTE_LOW, 1'b1, 1'b1, 1'b0, 4'd1);
        start   = 1'b1;
        cfg_len = 4'd1;
        cyc();
        start = 1'b0;
        expect_out("busy_start", NOTE_LOW, 1'b1, 1'b1, 1'b0, 4'd1);
        cyc();
        expect_out("live_s2", NOTE_TOP, 1'b0, 1'b1, 1'b0, 4'd2);
        stop   = 1'b1;
        snooze = 1'b1;
        cyc();
        stop   = 1'b0;
        snooze = 1'b0;
        expect_out("stop_snz", 13'h0, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc();
        expect_out("stop_snz_after", 13'h0, 1'b0, 1'b0, 1'b0, 4'd0);

        // start and stop together in IDLE stays idle.
        set_cfg(4'd3, 16'd2, 4'd1);
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        expect_out("start_stop_idle", 13'h0, 1'b0, 1'b0, 1'b0, 4'd0);

        // Reset mid-playback clears outputs and the pattern memory.
        load_tune();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        expect_out("rst_pre", NOTE_MID, 1'b1, 1'b1, 1'b0, 4'd0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        expect_out("rst_mid", 13'h0, 1'b0, 1'b0, 1'b0, 4'd0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        expect_out("rst_mem0", 13'h0, 1'b0, 1'b1, 1'b0, 4'd0);
        cyc();
        cyc();
        expect_out("rst_mem1", 13'h0, 1'b0, 1'b1, 1'b0, 4'd1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        expect_out("final_idle", 13'h0, 1'b0, 1'b0, 1'b0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
